// File: rtl/video_pixel_shifter_pkg.sv
// Shared video definitions: screen mode encodings, character slot length and ink index type.
// The palette stage imports the same package.
package video_pkg;

    localparam logic [1:0] MODE_0 = 2'd0;  // 160 px, 4 bpp
    localparam logic [1:0] MODE_1 = 2'd1;  // 320 px, 2 bpp
    localparam logic [1:0] MODE_2 = 2'd2;  // 640 px, 1 bpp
    localparam logic [1:0] MODE_3 = 2'd3;  // 160 px, 2 bpp

    localparam int SLOT_CYCLES = 8;

    // The watchdog saturates here; reaching it means the slot ran out without a new byte.
    localparam logic [3:0] WD_SAT = 4'(SLOT_CYCLES);

    typedef logic [3:0] ink_t;

    // True when dot counter value dc is the first cycle of a logical pixel in this mode.
    function automatic logic is_pixel_start(input logic [1:0] mode, input logic [2:0] dc);
        logic start;
        case (mode)
            MODE_2:  start = 1'b1;
            MODE_1:  start = ~dc[0];
            default: start = (dc[1:0] == 2'b00);
        endcase
        return start;
    endfunction

endpackage

// File: rtl/video_pixel_shifter_if.sv
// Byte path from the video buffer into the shifter, and dot stream out towards the palette.
// LOAD is a single-cycle strobe with no back-pressure: the byte, DISPEN and MODE are taken
// in the cycle LOAD is high; the dot outputs are plain registered levels valid every cycle.
interface video_pixel_shifter_if;
    import video_pkg::*;

    logic       LOAD;
    logic [7:0] VIDEO_BUF;
    logic       DISPEN_BUF;
    logic [1:0] MODE;
    ink_t       INK_IDX;
    logic       BORDER;
    logic       PIX_STROBE;

    modport master (
        output LOAD, VIDEO_BUF, DISPEN_BUF, MODE,
        input  INK_IDX, BORDER, PIX_STROBE
    );

    modport slave (
        input  LOAD, VIDEO_BUF, DISPEN_BUF, MODE,
        output INK_IDX, BORDER, PIX_STROBE
    );

endinterface

// File: rtl/video_pixel_shifter_pixel_decode.sv
// Combinational ink decode of the current shift register for a given screen mode.
// Bits are interleaved so one left shift moves every plane to its next pixel.
module pixel_decode
    import video_pkg::*;
(
    input  logic [7:0] sr,
    input  logic [1:0] ml,
    output ink_t       ink
);

    ink_t quad;
    logic unused_bits;

    // Even SR bits only become visible after a shift, so they are never read directly.
    assign unused_bits = ^{sr[6], sr[4], sr[2], sr[0]};

    always_comb begin
        ink  = '0;
        quad = {sr[1], sr[5], sr[3], sr[7]};
        case (ml)
            MODE_2:  ink = {3'b000, sr[7]};
            MODE_1:  ink = {2'b00, sr[3], sr[7]};
            MODE_0:  ink = quad;
            default: ink = quad & 4'b0011;
        endcase
    end

endmodule

// File: rtl/video_pixel_shifter.sv
// Loads the latched video byte on LOAD and serialises it into per-dot ink indices,
// with border forcing for blanked bytes and for a missing LOAD (underrun).
module video_pixel_shifter
    import video_pkg::*;
(
    input logic                  CLK_16,
    input logic                  RESET,
    video_pixel_shifter_if.slave vid
);

    logic [7:0] sr, sr_next;
    logic [1:0] ml, ml_next;
    logic       dl, dl_next;
    logic [2:0] dc, dc_next;
    logic [3:0] wd, wd_next;
    logic       shift_en;
    logic       underrun_next;
    logic       start_next;
    ink_t       dec_ink;

    ink_t       ink_q;
    logic       border_q;
    logic       strobe_q;

    // Shift on the last cycle of a pixel, i.e. when the next counter value opens a new one.
    always_comb begin
        shift_en      = is_pixel_start(ml, dc + 3'd1);
        sr_next       = shift_en ? {sr[6:0], 1'b0} : sr;
        ml_next       = ml;
        dl_next       = dl;
        dc_next       = dc + 3'd1;
        wd_next       = (wd == WD_SAT) ? wd : wd + 4'd1;
        if (vid.LOAD) begin
            sr_next = vid.VIDEO_BUF;
            ml_next = vid.MODE;
            dl_next = vid.DISPEN_BUF;
            dc_next = '0;
            wd_next = '0;
        end
        underrun_next = (wd_next == WD_SAT);
        start_next    = is_pixel_start(ml_next, dc_next);
    end

    // Outputs are decoded from next-state values so a LOAD shows its first dot one cycle later.
    pixel_decode u_pixel_decode (
        .sr  (sr_next),
        .ml  (ml_next),
        .ink (dec_ink)
    );

    always_ff @(posedge CLK_16) begin
        if (RESET) begin
            sr       <= '0;
            ml       <= MODE_0;
            dl       <= 1'b0;
            dc       <= '0;
            wd       <= WD_SAT;
            ink_q    <= '0;
            border_q <= 1'b1;
            strobe_q <= 1'b0;
        end else begin
            sr       <= sr_next;
            ml       <= ml_next;
            dl       <= dl_next;
            dc       <= dc_next;
            wd       <= wd_next;
            ink_q    <= underrun_next ? 4'd0 : dec_ink;
            border_q <= ~dl_next | underrun_next;
            strobe_q <= start_next & ~underrun_next;
        end
    end

    assign vid.INK_IDX    = ink_q;
    assign vid.BORDER     = border_q;
    assign vid.PIX_STROBE = strobe_q;

endmodule

// File: tb/tb_video_pixel_shifter.sv
// Self-checking bench for video_pixel_shifter: directed cycle table plus randomized
// byte stream checked against a slot-level dot model.
module tb_video_pixel_shifter;
    import video_pkg::*;

    logic clk;
    logic rst;
    video_pixel_shifter_if vif();

    video_pixel_shifter dut (
        .CLK_16 (clk),
        .RESET  (rst),
        .vid    (vif)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] exp_q[$];

    typedef struct {
        logic       rst;
        logic       load;
        logic [7:0] vbuf;
        logic       dis;
        logic [1:0] mode;
        logic [3:0] ink;
        logic       brd;
        logic       stb;
    } vec_t;

    vec_t vecs[$];

    // ---------------- reference model ----------------
    // Dots are derived from time since the last LOAD: dot t belongs to pixel t/duration.
    logic [7:0] m_byte;
    logic [1:0] m_mode;
    logic       m_dis;
    int         m_t;

    task automatic model_step(input logic r, input logic ld, input logic [7:0] vb,
                              input logic ds, input logic [1:0] md);
        if (r) begin
            m_byte = 8'h00; m_mode = 2'd0; m_dis = 1'b0; m_t = SLOT_CYCLES;
        end else if (ld) begin
            m_byte = vb; m_mode = md; m_dis = ds; m_t = 0;
        end else if (m_t < SLOT_CYCLES) begin
            m_t++;
        end
    endtask

    function automatic logic [5:0] model_out();
        int dur;
        int k;
        logic [3:0] ink;
        if (m_t >= SLOT_CYCLES) return {4'd0, 1'b1, 1'b0};
        dur = (m_mode == 2'd2) ? 1 : (m_mode == 2'd1) ? 2 : 4;
        k = m_t / dur;
        case (m_mode)
            2'd2:    ink = {3'b000, m_byte[7-k]};
            2'd1:    ink = {2'b00, m_byte[3-k], m_byte[7-k]};
            default: ink = {m_byte[1-k], m_byte[5-k], m_byte[3-k], m_byte[7-k]};
        endcase
        if (m_mode == 2'd3) ink = ink & 4'b0011;
        return {ink, ~m_dis, (m_t % dur) == 0};
    endfunction

    // ---------------- driver ----------------
    task automatic run_cycle(input logic r, input logic ld, input logic [7:0] vb,
                             input logic ds, input logic [1:0] md, output logic [5:0] got);
        rst            = r;
        vif.LOAD       = ld;
        vif.VIDEO_BUF  = vb;
        vif.DISPEN_BUF = ds;
        vif.MODE       = md;
        @(posedge clk);
        model_step(r, ld, vb, ds, md);
        #1;
        got = {vif.INK_IDX, vif.BORDER, vif.PIX_STROBE};
    endtask

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got ink=%0d border=%0b strobe=%0b, want ink=%0d border=%0b strobe=%0b",
                     name, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic add(input logic r, input logic ld, input logic [7:0] vb, input logic ds,
                       input logic [1:0] md, input logic [3:0] ink, input logic brd, input logic stb);
        vec_t v;
        v.rst = r; v.load = ld; v.vbuf = vb; v.dis = ds; v.mode = md;
        v.ink = ink; v.brd = brd; v.stb = stb;
        vecs.push_back(v);
    endtask

    // Idle cycle: no LOAD, MODE input set to md (must not affect the current byte).
    task automatic idle(input logic [1:0] md, input logic [3:0] ink, input logic brd, input logic stb);
        add(1'b0, 1'b0, 8'h00, 1'b0, md, ink, brd, stb);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] got;
        logic [5:0] exp;
        int gap;

        rst = 1'b1; vif.LOAD = 1'b0; vif.VIDEO_BUF = '0; vif.DISPEN_BUF = 1'b0; vif.MODE = '0;

        // Each row: inputs for cycle N, expected outputs in cycle N+1.
        add(1, 0, 8'h00, 0, 2'd0, 4'd0, 1, 0);               // reset state
        idle(2'd0, 4'd0, 1, 0);                              // underrun after reset
        // mode 2, 0xA5
        add(0, 1, 8'hA5, 1, 2'd2, 4'd1, 0, 1);
        idle(2'd2, 4'd0, 0, 1); idle(2'd2, 4'd1, 0, 1); idle(2'd2, 4'd0, 0, 1);
        idle(2'd2, 4'd0, 0, 1); idle(2'd2, 4'd1, 0, 1); idle(2'd2, 4'd0, 0, 1);
        idle(2'd2, 4'd1, 0, 1);
        idle(2'd2, 4'd0, 1, 0); idle(2'd2, 4'd0, 1, 0);       // underrun from N+9
        // mode 1, 0x88
        add(0, 1, 8'h88, 1, 2'd1, 4'd3, 0, 1);
        idle(2'd1, 4'd3, 0, 0); idle(2'd1, 4'd0, 0, 1); idle(2'd1, 4'd0, 0, 0);
        idle(2'd1, 4'd0, 0, 1); idle(2'd1, 4'd0, 0, 0); idle(2'd1, 4'd0, 0, 1);
        idle(2'd1, 4'd0, 0, 0);
        // mode 0, 0x02, contiguous with previous slot
        add(0, 1, 8'h02, 1, 2'd0, 4'd8, 0, 1);
        idle(2'd0, 4'd8, 0, 0); idle(2'd0, 4'd8, 0, 0); idle(2'd0, 4'd8, 0, 0);
        idle(2'd0, 4'd0, 0, 1); idle(2'd0, 4'd0, 0, 0); idle(2'd0, 4'd0, 0, 0);
        idle(2'd0, 4'd0, 0, 0);
        // mode 0, 0x40
        add(0, 1, 8'h40, 1, 2'd0, 4'd0, 0, 1);
        idle(2'd0, 4'd0, 0, 0); idle(2'd0, 4'd0, 0, 0); idle(2'd0, 4'd0, 0, 0);
        idle(2'd0, 4'd1, 0, 1); idle(2'd0, 4'd1, 0, 0); idle(2'd0, 4'd1, 0, 0);
        idle(2'd0, 4'd1, 0, 0);
        // mode 3, 0x82: 9 masked to 1
        add(0, 1, 8'h82, 1, 2'd3, 4'd1, 0, 1);
        idle(2'd3, 4'd1, 0, 0); idle(2'd3, 4'd1, 0, 0); idle(2'd3, 4'd1, 0, 0);
        idle(2'd3, 4'd0, 0, 1); idle(2'd3, 4'd0, 0, 0); idle(2'd3, 4'd0, 0, 0);
        idle(2'd3, 4'd0, 0, 0);
        // DISPEN=0: border for the whole byte
        add(0, 1, 8'hFF, 0, 2'd2, 4'd1, 1, 1);
        for (int i = 0; i < 7; i++) idle(2'd2, 4'd1, 1, 1);
        idle(2'd2, 4'd0, 1, 0);
        // MODE changes between loads are ignored
        add(0, 1, 8'hA5, 1, 2'd2, 4'd1, 0, 1);
        idle(2'd0, 4'd0, 0, 1); idle(2'd1, 4'd1, 0, 1); idle(2'd3, 4'd0, 0, 1);
        idle(2'd0, 4'd0, 0, 1); idle(2'd1, 4'd1, 0, 1); idle(2'd3, 4'd0, 0, 1);
        idle(2'd0, 4'd1, 0, 1);
        // early LOAD at N+3
        add(0, 1, 8'hA5, 1, 2'd2, 4'd1, 0, 1);
        idle(2'd0, 4'd0, 0, 1); idle(2'd0, 4'd1, 0, 1);
        add(0, 1, 8'h88, 1, 2'd1, 4'd3, 0, 1);
        idle(2'd1, 4'd3, 0, 0); idle(2'd1, 4'd0, 0, 1);
        // consecutive LOADs: second wins
        add(0, 1, 8'h02, 1, 2'd0, 4'd8, 0, 1);
        add(0, 1, 8'h40, 1, 2'd0, 4'd0, 0, 1);
        idle(2'd0, 4'd0, 0, 0); idle(2'd0, 4'd0, 0, 0); idle(2'd0, 4'd0, 0, 0);
        idle(2'd0, 4'd1, 0, 1);
        // reset mid-byte, then LOAD coincident with reset
        add(0, 1, 8'hA5, 1, 2'd2, 4'd1, 0, 1);
        idle(2'd2, 4'd0, 0, 1); idle(2'd2, 4'd1, 0, 1); idle(2'd2, 4'd0, 0, 1);
        add(1, 0, 8'h00, 0, 2'd2, 4'd0, 1, 0);
        add(1, 1, 8'hA5, 1, 2'd2, 4'd0, 1, 0);
        idle(2'd2, 4'd0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_cycle(vecs[i].rst, vecs[i].load, vecs[i].vbuf, vecs[i].dis, vecs[i].mode, got);
            check($sformatf("vec%0d", i), got, {vecs[i].ink, vecs[i].brd, vecs[i].stb});
        end

        // Randomized stream: mostly nominal 8-cycle slots, some early/late LOADs and resets.
        run_cycle(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, got);
        gap = 0;
        for (int c = 0; c < 3000; c++) begin
            logic ld;
            logic r;
            ld = 1'b0;
            if (gap == 0) begin
                ld  = 1'b1;
                gap = ($urandom_range(0, 9) < 7) ? 8 : int'($urandom_range(1, 14));
            end
            gap--;
            r = ($urandom_range(0, 299) == 0);
            run_cycle(r, ld, 8'($urandom), ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), got);
            exp_q.push_back(model_out());
            exp = exp_q.pop_front();
            check($sformatf("rand%0d", c), got, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
